// File: rtl/led_pdm_scanner.sv
// HUB75 64x64 1:32-scan driver: requests pixels from the painter, converts each
// channel to a bit-reversed-threshold PDM bit and shifts top/bottom pairs into the panel.
module led_pdm_scanner #(
  parameter int unsigned FRAME_BITS = 10,
  parameter int unsigned PAINT_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [FRAME_BITS-1:0] frame,
  output logic [7:0]            subframe,
  output logic [5:0]            x,
  output logic [5:0]            y,
  input  logic [23:0]           rgb24,
  output logic [2:0]            panel_rgb0,
  output logic [2:0]            panel_rgb1,
  output logic [4:0]            panel_addr,
  output logic                  panel_sclk,
  output logic                  panel_latch,
  output logic                  panel_blank
);

  localparam int unsigned N_LAST = 129 + PAINT_LAT;
  localparam int unsigned CW     = $clog2(N_LAST + 1);

  localparam logic [CW-1:0] C_LAST      = CW'(N_LAST);
  localparam logic [CW-1:0] C_LAT       = CW'(PAINT_LAT);
  localparam logic [CW-1:0] C_SAMP_END  = CW'(127 + PAINT_LAT);
  localparam logic [CW-1:0] C_SCLK_BEG  = CW'(2 + PAINT_LAT);
  localparam logic [CW-1:0] C_SCLK_END  = CW'(128 + PAINT_LAT);
  localparam logic [CW-1:0] C_REQ_END   = CW'(127);

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_UNBLANK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_n;
  logic [4:0]            r_row;
  logic [2:0]            r_top;
  logic [FRAME_BITS-1:0] r_frame;
  logic [7:0]            r_subframe;
  logic [5:0]            r_x;
  logic [5:0]            r_y;
  logic [2:0]            r_rgb0;
  logic [2:0]            r_rgb1;
  logic [4:0]            r_addr;
  logic                  r_sclk;
  logic                  r_latch;
  logic                  r_blank;

  logic [6:0]            w_n1;
  logic [7:0]            w_thr;
  logic [2:0]            w_pdm;
  logic                  w_shift;
  logic                  w_samp;
  logic                  w_bottom;
  logic                  w_sclk_set;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SHIFT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SHIFT:   if (r_n == C_LAST) w_state_nxt = ST_BLANK;
      ST_BLANK:   w_state_nxt = ST_LATCH;
      ST_LATCH:   w_state_nxt = ST_UNBLANK;
      ST_UNBLANK: w_state_nxt = ST_SHIFT;
      default:    w_state_nxt = ST_SHIFT;
    endcase
  end

  always_comb begin
    w_thr = '0;
    for (int unsigned i = 0; i < 8; i++) w_thr[i] = r_subframe[7-i];
  end

  assign w_pdm = {rgb24[23:16] > w_thr, rgb24[15:8] > w_thr, rgb24[7:0] > w_thr};

  // Request k = n - PAINT_LAT returns now; odd k is the bottom half of a column.
  assign w_shift    = (r_state == ST_SHIFT);
  assign w_n1       = r_n[6:0] + 7'd1;
  assign w_bottom   = r_n[0] ^ C_LAT[0];
  assign w_samp     = w_shift && (r_n >= C_LAT) && (r_n <= C_SAMP_END);
  assign w_sclk_set = w_shift && (r_n >= C_SCLK_BEG) && (r_n <= C_SCLK_END) && !w_bottom;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame    <= '0;
      r_subframe <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_rgb0     <= '0;
      r_rgb1     <= '0;
      r_addr     <= '0;
      r_sclk     <= 1'b0;
      r_latch    <= 1'b0;
      r_blank    <= 1'b1;
      r_n        <= '0;
      r_row      <= '0;
      r_top      <= '0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          r_n <= (r_n == C_LAST) ? '0 : r_n + CW'(1);
          if (r_n < C_REQ_END) begin
            r_x <= w_n1[6:1];
            r_y <= {w_n1[0], r_row};
          end
          if (w_samp) begin
            if (w_bottom) begin
              r_rgb0 <= r_top;
              r_rgb1 <= w_pdm;
            end else begin
              r_top <= w_pdm;
            end
          end
          r_sclk <= w_sclk_set;
          if (r_n == C_LAST) r_blank <= 1'b1;
        end
        ST_BLANK: begin
          r_latch <= 1'b1;
          r_addr  <= r_row;
        end
        ST_LATCH: begin
          r_latch <= 1'b0;
          r_blank <= 1'b0;
        end
        ST_UNBLANK: begin
          r_row <= r_row + 5'd1;
          r_x   <= '0;
          r_y   <= {1'b0, r_row + 5'd1};
          if (r_row == 5'd31) begin
            r_subframe <= r_subframe + 8'd1;
            if (r_subframe == 8'hFF) r_frame <= r_frame + FRAME_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign frame       = r_frame;
  assign subframe    = r_subframe;
  assign x           = r_x;
  assign y           = r_y;
  assign panel_rgb0  = r_rgb0;
  assign panel_rgb1  = r_rgb1;
  assign panel_addr  = r_addr;
  assign panel_sclk  = r_sclk;
  assign panel_latch = r_latch;
  assign panel_blank = r_blank;

endmodule
